// File: rtl/uart_word_sender_if.sv
// ---------------------------------------------------------------------------
// uart_word_sender_if
// Purpose : bundles the word-source handshake and the UART transmitter
//           strobe/busy signals used by uart_word_sender.
// Signals : send_en     - transmitter path enable (mirrored onto TX_EN)
//           word_in     - 16-bit word, [15:8] sent first
//           word_valid  - word_in valid
//           word_ready  - sender can accept a word
//           Tx_DATA     - byte presented to the UART transmitter
//           Tx_WR       - one-cycle write strobe to the transmitter
//           TX_EN       - transmitter enable
//           TX_BUSY     - transmitter busy
//           word_done   - one-cycle pulse after the low byte completes
//           tx_timeout  - sticky "transmitter never started" error
// Modports: master - word source / UART side (testbench)
//           slave  - the sender itself
// ---------------------------------------------------------------------------
interface uart_word_sender_if;
    logic        send_en;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  Tx_DATA;
    logic        Tx_WR;
    logic        TX_EN;
    logic        TX_BUSY;
    logic        word_done;
    logic        tx_timeout;

    modport master (
        output send_en, word_in, word_valid, TX_BUSY,
        input  word_ready, Tx_DATA, Tx_WR, TX_EN, word_done, tx_timeout
    );

    modport slave (
        input  send_en, word_in, word_valid, TX_BUSY,
        output word_ready, Tx_DATA, Tx_WR, TX_EN, word_done, tx_timeout
    );
endinterface

// File: rtl/uart_word_sender.sv
// ---------------------------------------------------------------------------
// uart_word_sender
// Purpose : takes one 16-bit word per handshake and hands it to the UART
//           transmitter as two bytes, high byte first, with a configurable
//           idle gap between them and a start timeout that latches a sticky
//           error if the transmitter never reports busy.
// Ports   : clk   - system clock
//           reset - asynchronous, active-low reset
//           bus   - uart_word_sender_if.slave (handshake + UART strobe/busy)
// Params  : GAP_CYCLES    - idle cycles between high-byte busy fall and the
//                           low-byte strobe (0 = strobe on the next cycle)
//           START_TIMEOUT - cycles to wait for TX_BUSY after a strobe
// ---------------------------------------------------------------------------
module uart_word_sender #(
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset,
    uart_word_sender_if.slave bus
);
    // +2 keeps the widths >= 1 and leaves headroom above the terminal value
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam int TO_W  = $clog2(START_TIMEOUT + 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_HI, S_WAIT_START_HI, S_WAIT_DONE_HI, S_GAP,
        S_LOAD_LO, S_WAIT_START_LO, S_WAIT_DONE_LO, S_FINISH, S_ERROR
    } state_t;

    state_t           r_state;
    logic [15:0]      r_word;
    logic [7:0]       r_tx_data;
    logic             r_tx_wr;
    logic             r_done;
    logic             r_timeout;
    logic             r_armed;     // holds word_ready low until the first edge after reset
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             w_accept;

    assign bus.TX_EN      = bus.send_en;
    assign bus.Tx_DATA    = r_tx_data;
    assign bus.Tx_WR      = r_tx_wr;
    assign bus.word_done  = r_done;
    assign bus.tx_timeout = r_timeout;
    assign bus.word_ready = r_armed && (r_state == S_IDLE) && bus.send_en && !r_timeout;
    assign w_accept       = bus.word_valid && bus.word_ready;

    // LOAD states: the strobe is raised on entry only if the transmitter was
    // idle at that edge; otherwise the state waits with Tx_WR low and raises
    // it (together with the data) on the first edge that sees TX_BUSY low.
    // r_tx_wr high inside a LOAD state means "strobe done, move on".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_tx_data <= '0;
            r_tx_wr   <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_armed   <= 1'b0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_armed <= 1'b1;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_word  <= bus.word_in;
                        r_state <= S_LOAD_HI;
                        if (!bus.TX_BUSY) begin
                            r_tx_wr   <= 1'b1;
                            r_tx_data <= bus.word_in[15:8];
                        end
                    end
                end
                S_LOAD_HI: begin
                    if (r_tx_wr) begin
                        r_tx_wr  <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= S_WAIT_START_HI;
                    end else if (!bus.TX_BUSY) begin
                        r_tx_wr   <= 1'b1;
                        r_tx_data <= r_word[15:8];
                    end
                end
                S_WAIT_START_HI: begin
                    if (bus.TX_BUSY) begin
                        r_state <= S_WAIT_DONE_HI;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_ONE;
                    end
                end
                S_WAIT_DONE_HI: begin
                    if (!bus.TX_BUSY) begin
                        if (GAP_CYCLES == 0) begin
                            // busy just sampled low, so strobe straight away
                            r_state   <= S_LOAD_LO;
                            r_tx_wr   <= 1'b1;
                            r_tx_data <= r_word[7:0];
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_LOAD_LO;
                        if (!bus.TX_BUSY) begin
                            r_tx_wr   <= 1'b1;
                            r_tx_data <= r_word[7:0];
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_ONE;
                    end
                end
                S_LOAD_LO: begin
                    if (r_tx_wr) begin
                        r_tx_wr  <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= S_WAIT_START_LO;
                    end else if (!bus.TX_BUSY) begin
                        r_tx_wr   <= 1'b1;
                        r_tx_data <= r_word[7:0];
                    end
                end
                S_WAIT_START_LO: begin
                    if (bus.TX_BUSY) begin
                        r_state <= S_WAIT_DONE_LO;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_ONE;
                    end
                end
                S_WAIT_DONE_LO: begin
                    if (!bus.TX_BUSY) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    r_tx_wr <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_sender.sv
// ---------------------------------------------------------------------------
// tb_uart_word_sender
// Two senders share clock and reset: one with a 5-cycle gap, one with no gap.
// A small UART model per sender raises TX_BUSY two edges after it samples a
// strobe and holds it for 20 edges. Expected bytes are queued when a word is
// handed over and popped when a strobe appears.
// ---------------------------------------------------------------------------
module tb_uart_word_sender;
    localparam int GAP = 5;
    localparam int TMO = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_word_sender_if bus ();
    uart_word_sender_if bus0 ();

    uart_word_sender #(.GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(rst_n), .bus(bus));
    uart_word_sender #(.GAP_CYCLES(0), .START_TIMEOUT(TMO)) dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt[2], done_cnt[2], wr_cyc[2], fall_cyc[2], lo_wr_cyc[2];
    int mode[2];                 // 0 normal, 1 never busy, 2 busy forced
    logic force_busy = 1'b0;
    logic [1:0] busy_r, w_wr, w_busy, w_done, w_ready, prev_busy;
    logic [7:0] w_data[2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int dly[2], hold[2];

    assign bus.TX_BUSY  = busy_r[0];
    assign bus0.TX_BUSY = busy_r[1];
    assign w_wr    = {bus0.Tx_WR, bus.Tx_WR};
    assign w_busy  = busy_r;
    assign w_done  = {bus0.word_done, bus.word_done};
    assign w_ready = {bus0.word_ready, bus.word_ready};
    assign w_data[0] = bus.Tx_DATA;
    assign w_data[1] = bus0.Tx_DATA;

    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter model
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                busy_r[d] <= 1'b0;
                dly[d] = 0;
                hold[d] = 0;
            end else if (mode[d] == 2) begin
                busy_r[d] <= force_busy;
            end else begin
                if (hold[d] > 0) begin
                    hold[d]--;
                    if (hold[d] == 0) busy_r[d] <= 1'b0;
                end
                if (dly[d] > 0) begin
                    dly[d]--;
                    if (dly[d] == 0) begin
                        busy_r[d] <= 1'b1;
                        hold[d] = 20;
                    end
                end
                if (w_wr[d] && mode[d] == 0) dly[d] = 2;
            end
        end
    end

    // Scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [7:0] e;
        logic have;
        for (int d = 0; d < 2; d++) begin
            if (w_wr[d]) begin
                checks++;
                have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (!have) begin
                    errors++;
                    $display("FAIL sb_unexpected_wr dut%0d: got strobe data %02h, expected no strobe", d, w_data[d]);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if (w_data[d] !== e) begin
                        errors++;
                        $display("FAIL sb_data dut%0d: got %02h expected %02h", d, w_data[d], e);
                    end
                end
                checks++;
                if (w_busy[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_while_busy dut%0d: TX_BUSY=%b expected 0", d, w_busy[d]);
                end
                wr_cnt[d]++;
                wr_cyc[d] = cyc;
                if (wr_cnt[d] % 2 == 0) lo_wr_cyc[d] = cyc;
            end
            if (prev_busy[d] && !w_busy[d] && (wr_cnt[d] % 2 == 1)) fall_cyc[d] = cyc;
            if (w_done[d]) done_cnt[d]++;
            prev_busy[d] = w_busy[d];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0;
            done_cnt[d] = 0;
            fall_cyc[d] = 0;
            lo_wr_cyc[d] = 0;
        end
    endtask

    task automatic send_word(input int d, input logic [15:0] w);
        int n = 0;
        while (w_ready[d] !== 1'b1 && n < 200) begin step(); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_ready_wait dut%0d: word_ready=%b expected 1 within 200 cycles", d, w_ready[d]);
        end
        if (d == 0) begin
            bus.word_in = w; bus.word_valid = 1'b1;
            q0.push_back(w[15:8]); q0.push_back(w[7:0]);
        end else begin
            bus0.word_in = w; bus0.word_valid = 1'b1;
            q1.push_back(w[15:8]); q1.push_back(w[7:0]);
        end
        step();
        bus.word_valid = 1'b0;
        bus0.word_valid = 1'b0;
    endtask

    task automatic wait_done(input int d, input int target);
        int n = 0;
        while (done_cnt[d] < target && n < 500) begin step(); n++; end
        checks++;
        if (done_cnt[d] < target) begin
            errors++;
            $display("FAIL wait_done dut%0d: word_done count %0d expected %0d", d, done_cnt[d], target);
        end
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if ({bus.Tx_WR, bus.Tx_DATA, bus.word_done, bus.tx_timeout, bus.word_ready} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b data=%02h done=%b tmo=%b rdy=%b expected all 0",
                     bus.Tx_WR, bus.Tx_DATA, bus.word_done, bus.tx_timeout, bus.word_ready);
        end
        rst_n = 1'b1;
        checks++;
        if (bus.word_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", bus.word_ready);
        end
        step();
        checks++;
        if (bus.word_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b expected 1", bus.word_ready);
        end
    endtask

    task automatic test_send_en();
        bus.send_en = 1'b0;
        #1;
        checks++;
        if (bus.word_ready !== 1'b0 || bus.TX_EN !== 1'b0) begin
            errors++;
            $display("FAIL send_en_low: got rdy=%b en=%b expected 0 0", bus.word_ready, bus.TX_EN);
        end
        bus.send_en = 1'b1;
        #1;
        checks++;
        if (bus.word_ready !== 1'b1 || bus.TX_EN !== 1'b1) begin
            errors++;
            $display("FAIL send_en_high: got rdy=%b en=%b expected 1 1", bus.word_ready, bus.TX_EN);
        end
    endtask

    task automatic test_basic();
        logic ready_seen = 1'b0;
        int n = 0;
        clear_counts();
        send_word(0, 16'hA53C);
        while (done_cnt[0] == 0 && n < 500) begin
            if (bus.word_ready !== 1'b0) ready_seen = 1'b1;
            step(); n++;
        end
        checks++;
        if (ready_seen !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_busy: got word_ready=1 mid-word, expected 0");
        end
        checks++;
        if (done_cnt[0] != 1 || wr_cnt[0] != 2) begin
            errors++;
            $display("FAIL basic_counts: got done=%0d wr=%0d expected 1 2", done_cnt[0], wr_cnt[0]);
        end
        checks++;
        if (lo_wr_cyc[0] - fall_cyc[0] != GAP + 1) begin
            errors++;
            $display("FAIL basic_gap: got %0d cycles expected %0d", lo_wr_cyc[0] - fall_cyc[0], GAP + 1);
        end
        step(); step();
        checks++;
        if (done_cnt[0] != 1 || bus.word_ready !== 1'b1 || q0.size() != 0) begin
            errors++;
            $display("FAIL basic_end: got done=%0d rdy=%b queued=%0d expected 1 1 0",
                     done_cnt[0], bus.word_ready, q0.size());
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int t_cyc;
        clear_counts();
        mode[0] = 1;
        send_word(0, 16'h1111);
        while (bus.tx_timeout !== 1'b1 && n < 200) begin step(); n++; end
        t_cyc = cyc;
        // one LOAD_HI cycle, then WAIT_START_HI with the counter at 0..TMO,
        // then the flag is visible: TMO+2 cycles after the strobe
        checks++;
        if (t_cyc - wr_cyc[0] != TMO + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", t_cyc - wr_cyc[0], TMO + 2);
        end
        bus.word_valid = 1'b1;
        repeat (40) step();
        checks++;
        if (bus.tx_timeout !== 1'b1 || bus.word_ready !== 1'b0 || wr_cnt[0] != 1 || bus.Tx_WR !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got tmo=%b rdy=%b wr=%0d txwr=%b expected 1 0 1 0",
                     bus.tx_timeout, bus.word_ready, wr_cnt[0], bus.Tx_WR);
        end
        bus.word_valid = 1'b0;
        rst_n = 1'b0;
        mode[0] = 0;
        step();
        checks++;
        if (bus.tx_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reset_clear: got %b expected 0", bus.tx_timeout);
        end
        rst_n = 1'b1;
        q0.delete();
        step();
    endtask

    task automatic test_stuck_busy();
        clear_counts();
        force_busy = 1'b1;
        mode[0] = 2;
        step(); step();
        send_word(0, 16'hA55A);
        repeat (10) step();
        checks++;
        if (wr_cnt[0] != 0) begin
            errors++;
            $display("FAIL stuck_no_strobe: got %0d strobes expected 0", wr_cnt[0]);
        end
        force_busy = 1'b0;
        step();
        mode[0] = 0;
        wait_done(0, 1);
        checks++;
        if (wr_cnt[0] != 2 || q0.size() != 0) begin
            errors++;
            $display("FAIL stuck_release: got wr=%0d queued=%0d expected 2 0", wr_cnt[0], q0.size());
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int d_before;
        clear_counts();
        send_word(0, 16'h0F0F);
        while (!(wr_cnt[0] == 2 && w_busy[0]) && n < 300) begin step(); n++; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.Tx_WR, bus.Tx_DATA, bus.word_done, bus.tx_timeout, bus.word_ready} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got wr=%b data=%02h done=%b tmo=%b rdy=%b expected all 0",
                     bus.Tx_WR, bus.Tx_DATA, bus.word_done, bus.tx_timeout, bus.word_ready);
        end
        q0.delete();
        repeat (3) step();
        rst_n = 1'b1;
        d_before = done_cnt[0];
        repeat (5) step();
        checks++;
        if (done_cnt[0] != 0 || d_before != 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", done_cnt[0]);
        end
        send_word(0, 16'hC3E1);
        wait_done(0, 1);
        checks++;
        if (wr_cnt[0] != 4 || q0.size() != 0) begin
            errors++;
            $display("FAIL midreset_next_word: got wr=%0d queued=%0d expected 4 0", wr_cnt[0], q0.size());
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        clear_counts();
        while (bus.word_ready !== 1'b1 && n < 100) begin step(); n++; end
        bus.word_in = 16'h1357; bus.word_valid = 1'b1;
        q0.push_back(8'h13); q0.push_back(8'h57);
        step();
        bus.word_in = 16'h2468;
        n = 0;
        while (bus.word_done !== 1'b1 && n < 500) begin step(); n++; end
        checks++;
        if (bus.word_done !== 1'b1 || bus.word_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_finish: got done=%b rdy=%b expected 1 0", bus.word_done, bus.word_ready);
        end
        q0.push_back(8'h24); q0.push_back(8'h68);
        step();
        checks++;
        if (bus.word_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_idle: got rdy=%b expected 1", bus.word_ready);
        end
        step();
        bus.word_valid = 1'b0;
        checks++;
        if (bus.Tx_WR !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_strobe: got Tx_WR=%b expected 1", bus.Tx_WR);
        end
        wait_done(0, 2);
        checks++;
        if (wr_cnt[0] != 4 || q0.size() != 0) begin
            errors++;
            $display("FAIL b2b_counts: got wr=%0d queued=%0d expected 4 0", wr_cnt[0], q0.size());
        end
        step();
    endtask

    task automatic test_gap0();
        clear_counts();
        send_word(1, 16'h5AC3);
        wait_done(1, 1);
        checks++;
        if (wr_cnt[1] != 2 || lo_wr_cyc[1] - fall_cyc[1] != 1) begin
            errors++;
            $display("FAIL gap0_timing: got wr=%0d gap=%0d expected 2 1", wr_cnt[1], lo_wr_cyc[1] - fall_cyc[1]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        mode[0] = 0; mode[1] = 0;
        prev_busy = 2'b00;
        bus.send_en = 1'b1;  bus.word_in = 16'h0;  bus.word_valid = 1'b0;
        bus0.send_en = 1'b1; bus0.word_in = 16'h0; bus0.word_valid = 1'b0;
        clear_counts();
        test_reset();
        test_send_en();
        test_basic();
        test_timeout();
        test_stuck_busy();
        test_reset_mid();
        test_back_to_back();
        test_gap0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_word_sender.md
Name: uart_word_sender

Overview:
- Transmit-side counterpart of the 16-bit packet assembler that drives the LED display.
- Accepts one 16-bit word per handshake and sends it to the UART transmitter as two 8-bit packets: high byte first, then low byte.
- Sits between the word source (switches or test logic) and the uart instance's Tx_DATA/Tx_WR/TX_EN/TX_BUSY interface.
- Adds a configurable inter-byte gap and a start timeout, so a stalled transmitter is reported instead of hanging the block.

Parameters:
- GAP_CYCLES, 16, idle clk cycles between end of the high byte (TX_BUSY fall) and the Tx_WR for the low byte; 0 is legal.
- START_TIMEOUT, 255, max clk cycles to wait for TX_BUSY to rise after a Tx_WR pulse before flagging an error.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- send_en  input  1  enables the transmitter path; driven straight to TX_EN.
- word_in  input  16  word to send; [15:8] is sent first.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  block can accept a word (IDLE only).
- Tx_DATA  output  8  byte presented to the UART transmitter.
- Tx_WR  output  1  one-cycle write strobe to the UART transmitter.
- TX_EN  output  1  transmitter enable (equals send_en).
- TX_BUSY  input  1  UART transmitter busy.
- word_done  output  1  one-cycle pulse after the low byte completes.
- tx_timeout  output  1  sticky error: TX_BUSY never rose within START_TIMEOUT.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; Tx_DATA=8'h00; Tx_WR=0; word_done=0; tx_timeout=0; word_ready=0.
  - Internal word register=0; gap and timeout counters=0.
  - word_ready goes to 1 on the first clk edge after reset release.
- TX_EN = send_en (combinational).
- word_ready = 1 only in IDLE with send_en=1 and tx_timeout=0.
- Accept: word_valid && word_ready on a clk edge latches word_in and moves to LOAD_HI. word_in may change afterwards.
- FSM states: IDLE, LOAD_HI, WAIT_START_HI, WAIT_DONE_HI, GAP, LOAD_LO, WAIT_START_LO, WAIT_DONE_LO, FINISH, ERROR.
  - LOAD_HI: Tx_DATA=word[15:8], Tx_WR=1 for exactly this one cycle. Next: WAIT_START_HI, timeout counter cleared.
  - WAIT_START_HI: TX_BUSY=1 goes to WAIT_DONE_HI. Otherwise the counter increments; counter==START_TIMEOUT sets tx_timeout and goes to ERROR.
  - WAIT_DONE_HI: TX_BUSY=0 goes to GAP (gap counter cleared), or straight to LOAD_LO if GAP_CYCLES=0.
  - GAP: counts GAP_CYCLES cycles, then goes to LOAD_LO.
  - LOAD_LO, WAIT_START_LO, WAIT_DONE_LO: same as the high-byte path with word[7:0]. TX_BUSY fall goes to FINISH.
  - FINISH: word_done=1 for one cycle, then IDLE.
  - ERROR: Tx_WR=0. Stays in ERROR until reset. tx_timeout stays 1.
- Tx_DATA holds its value from the LOAD cycle until the next LOAD. It is never changed while TX_BUSY=1.
- Tx_WR is never asserted while TX_BUSY=1. If TX_BUSY is already 1 on entry to a LOAD state, the FSM holds in LOAD with Tx_WR=0 until TX_BUSY=0, then strobes.
- send_en dropping mid-word does not abort the word: the FSM completes or times out. New words are refused while send_en=0.
- Counters saturate at their terminal value; no wrap.
- Reset mid-word: immediate return to IDLE. The partial word is discarded and no word_done is pulsed.
- word_valid held high across FINISH: the next word is accepted on the first IDLE cycle, never in the FINISH cycle.

Test Plan:
- Reset, send_en=1, word_in=16'hA53C with word_valid for one cycle; UART model asserts TX_BUSY 2 cycles after each Tx_WR and holds it 20 cycles.
  - Required: Tx_WR pulses with Tx_DATA=8'hA5, then 8'h3C.
  - Second Tx_WR exactly GAP_CYCLES+1 cycles after the first TX_BUSY fall.
  - One word_done pulse; word_ready=0 from accept until IDLE.
- Loopback through the uart instance into the packet assembler, sending 16'h1234 then 16'hFFFF at each baud_select 0..7. Required: assembler outputs 16'h1234 then 16'hFFFF, with no FERROR/PERROR.
- UART model never asserts TX_BUSY. Required: after LOAD_HI plus START_TIMEOUT cycles, tx_timeout=1, word_ready stays 0, no further Tx_WR; only reset clears it.
- TX_BUSY stuck at 1 when a word is accepted. Required: no Tx_WR until TX_BUSY falls, then exactly one strobe with 8'hA5.
- Pull reset low during WAIT_DONE_LO. Required: all outputs at reset values immediately, no word_done, clean transfer of the next word.
- GAP_CYCLES=0 build. Required: LOAD_LO strobe occurs in the cycle after the high-byte TX_BUSY fall.
